// File: rtl/systolic_buffer_drain.sv
// systolic_buffer_drain
//   Read-side controller for the systolic output buffer. The buffer stores
//   skewed results (column j of row r lives at address r+j). This block sweeps
//   addresses 0..NUM_ROWS+N_SIZE-2, de-skews the columns through per-column
//   delay lines and streams aligned rows over valid/ready.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   start         one-cycle pulse, begins a drain when idle
//   busy          high from accepted start until the final row handshake
//   done          one-cycle pulse after the final row handshake
//   rd_addr       buffer read address (combinational)
//   rd_data       buffer read data, valid one cycle after rd_addr
//   m_valid/m_ready/m_data/m_last/m_row_idx   aligned row stream
//   stall_cnt     (only with DRAIN_STALL_CNT_EN) cycles with busy && m_valid && !m_ready
//
// Optional feature macro: DRAIN_STALL_CNT_EN

// One column's de-skew delay line: DLY stages, shifting only on capture.
module systolic_drain_col #(
  parameter int DW  = 32,
  parameter int DLY = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] tap
);
  logic [DLY-1:0][DW-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (en) begin
      sr[0] <= din;
      for (int i = 1; i < DLY; i++) sr[i] <= sr[i-1];
    end
  end

  // Oldest stage: the word captured DLY captures ago.
  assign tap = sr[DLY-1];
endmodule

module systolic_buffer_drain #(
  parameter int DATAWIDTH_output = 32,
  parameter int N_SIZE           = 32,
  parameter int NUM_ROWS         = 512,
  parameter int ADDR_WIDTH       = 10
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  output logic                                 busy,
  output logic                                 done,
  output logic [ADDR_WIDTH-1:0]                rd_addr,
  input  logic [DATAWIDTH_output*N_SIZE-1:0]   rd_data,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [DATAWIDTH_output*N_SIZE-1:0]   m_data,
  output logic                                 m_last,
  output logic [ADDR_WIDTH-1:0]                m_row_idx
`ifdef DRAIN_STALL_CNT_EN
  ,
  output logic [31:0]                          stall_cnt
`endif
);
  localparam int DW    = DATAWIDTH_output;
  localparam int DEPTH = NUM_ROWS + N_SIZE - 1;
  // One extra bit so ptr can reach DEPTH even when DEPTH == 2^ADDR_WIDTH.
  localparam int CW    = ADDR_WIDTH + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]                  state;
  logic [CW-1:0]               ptr;
  logic [CW-1:0]               cap_cnt;
  logic                        rd_vld;   // rd_data carries a word issued in DRAIN
  logic                        advance;
  logic                        issue;
  logic                        cap_en;
  logic                        row_load;
  logic [N_SIZE-1:0][DW-1:0]   rd_cols;
  logic [N_SIZE-1:0][DW-1:0]   row_nxt;
  logic [N_SIZE-1:0][DW-1:0]   m_row;

  assign advance  = !m_valid || m_ready;
  assign issue    = (state == ST_DRAIN) && (ptr < CW'(DEPTH));
  assign cap_en   = advance && rd_vld;
  // Captures 0..N_SIZE-2 only prime the delay lines.
  assign row_load = cap_en && (cap_cnt >= CW'(N_SIZE - 1));
  assign rd_cols  = rd_data;
  assign m_data   = m_row;
  assign busy     = (state == ST_DRAIN);
  assign done     = (state == ST_DONE);

  // Re-read the previous address while stalled so rd_data stays put. Once the
  // sweep is complete the last valid address is held instead of DEPTH.
  always_comb begin
    if (advance && (ptr < CW'(DEPTH))) rd_addr = ptr[ADDR_WIDTH-1:0];
    else                               rd_addr = ADDR_WIDTH'(ptr - 1'b1);
  end

  // Column j needs buffer word r+j while column N_SIZE-1 needs r+N_SIZE-1,
  // so column j is delayed by N_SIZE-1-j captures; the last column is direct.
  for (genvar j = 0; j < N_SIZE - 1; j++) begin : g_col
    systolic_drain_col #(.DW(DW), .DLY(N_SIZE - 1 - j)) u_col (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (cap_en),
      .din   (rd_cols[j]),
      .tap   (row_nxt[j])
    );
  end
  assign row_nxt[N_SIZE-1] = rd_cols[N_SIZE-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      cap_cnt   <= '0;
      rd_vld    <= 1'b0;
      m_valid   <= 1'b0;
      m_row     <= '0;
      m_row_idx <= '0;
      m_last    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state   <= ST_DRAIN;
          ptr     <= '0;
          cap_cnt <= '0;
        end
        ST_DRAIN: if (m_valid && m_ready && m_last) state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase

      if (advance) begin
        if (issue)  ptr     <= ptr + 1'b1;
        rd_vld <= issue;
        if (cap_en) cap_cnt <= cap_cnt + 1'b1;
        if (row_load) begin
          m_valid   <= 1'b1;
          m_row     <= row_nxt;
          // Row index = (cap_cnt+1) - N_SIZE.
          m_row_idx <= ADDR_WIDTH'(cap_cnt - CW'(N_SIZE - 1));
          m_last    <= (cap_cnt == CW'(DEPTH - 1));
        end else begin
          m_valid   <= 1'b0;
        end
      end
    end
  end

`ifdef DRAIN_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if ((state == ST_IDLE) && start) begin
      stall_cnt <= '0;
    end else if (busy && m_valid && !m_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_buffer_drain.sv
module tb_systolic_buffer_drain;
  localparam int DW    = 32;
  localparam int N     = 32;
  localparam int ROWS  = 512;
  localparam int AW    = 10;
  localparam int DEPTH = ROWS + N - 1;
  localparam int W     = DW * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          m_ready = 1'b0;
  logic          busy, done, m_valid, m_last;
  logic [AW-1:0] rd_addr, m_row_idx;
  logic [W-1:0]  rd_data, m_data;
`ifdef DRAIN_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [W-1:0] mem [1024];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rd_data <= mem[rd_addr];

  systolic_buffer_drain #(
    .DATAWIDTH_output(DW), .N_SIZE(N), .NUM_ROWS(ROWS), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .m_row_idx(m_row_idx)
`ifdef DRAIN_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_row(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int j = 0; j < N; j++) begin
        if (act[j*DW +: DW] !== exp[j*DW +: DW]) begin
          $display("FAIL %s col %0d: got %h expected %h", name, j, act[j*DW +: DW], exp[j*DW +: DW]);
          break;
        end
      end
    end
  endtask

  // Buffer contents: column j of address a = (a*64+j) ^ salt.
  task automatic preload(input logic [31:0] salt);
    for (int a = 0; a < 1024; a++)
      for (int j = 0; j < N; j++)
        mem[a][j*DW +: DW] = 32'(a * 64 + j) ^ salt;
  endtask

  // Reference: aligned row r takes column j from buffer word r+j.
  function automatic logic [W-1:0] model_row(input int r);
    logic [W-1:0] v;
    for (int j = 0; j < N; j++) v[j*DW +: DW] = mem[r+j][j*DW +: DW];
    return v;
  endfunction

  // Ready patterns: 0 always ready, 1 random 50%, 2 hold 0 for 50 valid cycles.
  int rmode = 0;
  int hold_cnt = 0;
  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       m_ready = 1'b1;
      1:       m_ready = (($urandom % 2) == 1);
      default: begin
        if (hold_cnt < 50) begin
          m_ready = 1'b0;
          if (m_valid) hold_cnt++;
        end else begin
          m_ready = 1'b1;
        end
      end
    endcase
  end

  // Compare process.
  int           exp_idx = 0;
  int           done_cnt = 0;
  int           first_cyc = 0;
  int           start_cyc = 0;
  int           max_addr = 0;
  bit           have_prev = 0, prev_stall = 0, last_hs = 0, seen_valid = 0;
  logic [W-1:0] prev_data;
  logic [AW-1:0] prev_idx, prev_addr;
  logic         prev_last;
  logic [DW-1:0] lit_r0c1, lit_r511c31;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_m_valid", m_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_m_row_idx", m_row_idx, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk_row("rst_m_data", m_data, '0);
      exp_idx = 0; have_prev = 0; prev_stall = 0; last_hs = 0;
    end else begin
      if (last_hs) chk("done_after_last", done, 1);
      if (done) begin
        chk("done_rows", exp_idx, ROWS);
        chk("done_busy", busy, 0);
        done_cnt++;
        exp_idx = 0;
      end
      if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
      if (m_valid) begin
        if (!seen_valid) begin seen_valid = 1; first_cyc = cyc; end
        if (exp_idx >= ROWS) begin
          chk("extra_row", m_valid, 0);
        end else begin
          chk_row("row_data", m_data, model_row(exp_idx));
          chk("row_idx", m_row_idx, exp_idx);
          chk("row_last", m_last, (exp_idx == ROWS - 1));
          chk("busy_with_valid", busy, 1);
          if (exp_idx == 0)        lit_r0c1    = m_data[DW +: DW];
          if (exp_idx == ROWS - 1) lit_r511c31 = m_data[(N-1)*DW +: DW];
        end
      end
      if (prev_stall) begin
        chk("stall_valid", m_valid, 1);
        chk_row("stall_data", m_data, prev_data);
        chk("stall_idx", m_row_idx, prev_idx);
        chk("stall_last", m_last, prev_last);
      end
      if (m_valid && !m_ready && have_prev) chk("stall_addr", rd_addr, prev_addr);
      last_hs = m_valid && m_ready && (exp_idx == ROWS - 1);
      if (m_valid && m_ready) exp_idx++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_idx   = m_row_idx;
      prev_last  = m_last;
      prev_addr  = rd_addr;
      have_prev  = 1;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int base);
    int n = 0;
    while (done_cnt == base && n < 20000) begin @(posedge clk); n++; end
    chk("done_count", done_cnt, base + 1);
  endtask

  task automatic wait_row(input int r);
    int n = 0;
    while (exp_idx < r && n < 5000) begin @(negedge clk); n++; end
    chk("row_reached", (exp_idx >= r), 1);
  endtask

  int base;

  initial begin
    preload(32'd0);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Full drain, always ready, reference preload.
    rmode = 0; seen_valid = 0; max_addr = 0; base = done_cnt;
    pulse_start();
    wait_done(base);
    chk("first_valid_latency", first_cyc - start_cyc, 33);
    chk("lit_row0_col1", lit_r0c1, 65);
    chk("lit_row511_col31", lit_r511c31, 34719);
    chk("max_rd_addr_ready", max_addr, DEPTH - 1);
    repeat (2) @(negedge clk);
    chk("busy_after_done", busy, 0);

    // Random backpressure, random contents.
    preload($urandom);
    rmode = 1; max_addr = 0; base = done_cnt;
    pulse_start();
    wait_done(base);
    chk("max_rd_addr_random", max_addr, DEPTH - 1);

    // Extra start pulses mid-drain are ignored.
    preload($urandom);
    base = done_cnt;
    pulse_start();
    wait_row(10);
    pulse_start();
    wait_row(300);
    pulse_start();
    wait_done(base);
    repeat (5) @(negedge clk);
    chk("no_restart_busy", busy, 0);
    chk("no_extra_done", done_cnt, base + 1);

    // Reset in the middle of a drain.
    rmode = 0; base = done_cnt;
    pulse_start();
    wait_row(100);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", m_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk_row("async_rst_data", m_data, '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_done_after_rst", done_cnt, base);
    preload($urandom);
    rmode = 1; base = done_cnt;
    pulse_start();
    wait_done(base);

    // Downstream holds off for 50 cycles on row 0.
    preload(32'd0);
    hold_cnt = 0; rmode = 2; base = done_cnt;
    pulse_start();
    wait_done(base);
`ifdef DRAIN_STALL_CNT_EN
    chk("stall_cnt_at_done", stall_cnt, 50);
    rmode = 0; base = done_cnt;
    pulse_start();
    chk("stall_cnt_cleared", stall_cnt, 0);
    wait_done(base);
`endif
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
